// File: rtl/ps2_key_decoder_pkg.sv
// Shared scancode constants, parser state encoding, event record and letter lookup
// for the PS/2 set-2 key decoder.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_EXT     = 5'b00010,
    ST_BRK     = 5'b00100,
    ST_EXT_BRK = 5'b01000,
    ST_PAUSE   = 5'b10000
  } state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] ascii;
    logic [7:0] code;
  } evt_t;

  // Lowercase letter for a set-2 scancode, 0x00 when the code is not a letter.
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    case (code)
      8'h1C: return "a";  8'h32: return "b";  8'h21: return "c";  8'h23: return "d";
      8'h24: return "e";  8'h2B: return "f";  8'h34: return "g";  8'h33: return "h";
      8'h43: return "i";  8'h3B: return "j";  8'h42: return "k";  8'h4B: return "l";
      8'h3A: return "m";  8'h31: return "n";  8'h44: return "o";  8'h4D: return "p";
      8'h15: return "q";  8'h2D: return "r";  8'h1B: return "s";  8'h2C: return "t";
      8'h3C: return "u";  8'h2A: return "v";  8'h1D: return "w";  8'h22: return "x";
      8'h35: return "y";  8'h1A: return "z";
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_decoder_ascii_lut.sv
// Combinational scancode-to-ASCII translation honouring shift, ctrl and caps-lock.
// Extended (E0) codes and unmapped codes translate to 0x00.
module ps2_key_decoder_ascii_lut
  import ps2_key_decoder_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       ctrl,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] digit;
  logic [7:0] symbol;
  logic [7:0] special;

  always_comb begin
    letter  = letter_of(code);
    digit   = 8'h00;
    symbol  = 8'h00;
    special = 8'h00;
    case (code)
      8'h16: begin digit = "1"; symbol = "!"; end
      8'h1E: begin digit = "2"; symbol = "@"; end
      8'h26: begin digit = "3"; symbol = "#"; end
      8'h25: begin digit = "4"; symbol = "$"; end
      8'h2E: begin digit = "5"; symbol = "%"; end
      8'h36: begin digit = "6"; symbol = "^"; end
      8'h3D: begin digit = "7"; symbol = "&"; end
      8'h3E: begin digit = "8"; symbol = "*"; end
      8'h46: begin digit = "9"; symbol = "("; end
      8'h45: begin digit = "0"; symbol = ")"; end
      8'h29: special = 8'h20;
      8'h5A: special = 8'h0D;
      8'h66: special = 8'h08;
      8'h0D: special = 8'h09;
      8'h76: special = 8'h1B;
      default: ;
    endcase

    ascii = 8'h00;
    if (!ext) begin
      // ctrl wins over case: ctrl+a..z maps onto 0x01..0x1A
      if (letter != 8'h00) begin
        if (ctrl)               ascii = letter - 8'h60;
        else if (shift ^ caps)  ascii = letter - 8'h20;
        else                    ascii = letter;
      end else if (digit != 8'h00) begin
        ascii = shift ? symbol : digit;
      end else begin
        ascii = special;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode parser with modifier tracking, ASCII translation, event FIFO,
// held-key display registers and a release counter.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 8,
  parameter int TIMEOUT_CYC  = 65535,
  parameter bit SUPPRESS_RPT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic [7:0]       evt_ascii,
  output logic             evt_ext,
  output logic             disp_en,
  output logic [7:0]       disp_code,
  output logic [7:0]       disp_ascii,
  output logic             shift_flag,
  output logic             ctrl_flag,
  output logic             caps_flag,
  output logic [CNT_W-1:0] key_cnt,
  output logic             ovf
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t           state_reg, state_next;
  logic [2:0]       skip_reg, skip_next;
  logic [TMO_W-1:0] tmo_reg;
  logic             timeout_hit, make_fire, brk_fire, ev_ext;

  logic             shift_l_reg, shift_r_reg, ctrl_l_reg, ctrl_r_reg;
  logic             caps_reg, caps_held_reg, disp_en_reg, ovf_reg;
  logic [7:0]       disp_code_reg, disp_ascii_reg, ascii;
  logic [8:0]       held_reg, key;
  logic [CNT_W-1:0] key_cnt_reg;

  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, fill;
  evt_t             mem [FIFO_DEPTH];
  evt_t             head;
  logic             is_lshift, is_rshift, is_lctrl, is_rctrl, is_caps, is_mod;
  logic             push_req, push_ok, pop, full, drop;

  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_reg != ST_IDLE) && !ps2_valid &&
                       (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    make_fire  = 1'b0;
    brk_fire   = 1'b0;
    ev_ext     = 1'b0;
    if (ps2_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (ps2_data == SC_E0)      state_next = ST_EXT;
          else if (ps2_data == SC_F0) state_next = ST_BRK;
          else if (ps2_data == SC_E1) begin
            state_next = ST_PAUSE;
            skip_next  = PAUSE_SKIP;
          end else                    make_fire = 1'b1;
        end
        ST_EXT: begin
          ev_ext = 1'b1;
          if (ps2_data == SC_F0) state_next = ST_EXT_BRK;
          else if (ps2_data != SC_E0) begin
            make_fire  = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (ps2_data != SC_F0) begin
            brk_fire   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          ev_ext     = 1'b1;
          brk_fire   = 1'b1;
          state_next = ST_IDLE;
        end
        ST_PAUSE: begin
          skip_next = skip_reg - 3'd1;
          if (skip_reg == 3'd1) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
    end
  end

  assign key       = {ev_ext, ps2_data};
  assign is_lshift = (key == {1'b0, SC_LSHIFT});
  assign is_rshift = (key == {1'b0, SC_RSHIFT});
  assign is_lctrl  = (key == {1'b0, SC_CTRL});
  assign is_rctrl  = (key == {1'b1, SC_CTRL});
  assign is_caps   = (key == {1'b0, SC_CAPS});
  assign is_mod    = is_lshift | is_rshift | is_lctrl | is_rctrl | is_caps;

  assign shift_flag = shift_l_reg | shift_r_reg;
  assign ctrl_flag  = ctrl_l_reg | ctrl_r_reg;
  assign caps_flag  = caps_reg;

  ps2_key_decoder_ascii_lut u_lut (
    .code  (ps2_data),
    .ext   (ev_ext),
    .shift (shift_flag),
    .ctrl  (ctrl_flag),
    .caps  (caps_reg),
    .ascii (ascii)
  );

  // A typematic repeat is a make of the key that is still shown as held.
  assign push_req = make_fire && !is_mod &&
                    !(SUPPRESS_RPT && disp_en_reg && (key == held_reg));
  assign fill     = wr_ptr_reg - rd_ptr_reg;
  assign full     = (fill == PW'(FIFO_DEPTH));
  assign pop      = evt_valid && evt_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      skip_reg       <= '0;
      tmo_reg        <= '0;
      shift_l_reg    <= 1'b0;
      shift_r_reg    <= 1'b0;
      ctrl_l_reg     <= 1'b0;
      ctrl_r_reg     <= 1'b0;
      caps_reg       <= 1'b0;
      caps_held_reg  <= 1'b0;
      disp_en_reg    <= 1'b0;
      disp_code_reg  <= '0;
      disp_ascii_reg <= '0;
      held_reg       <= '0;
      key_cnt_reg    <= '0;
      ovf_reg        <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
      tmo_reg   <= (state_reg == ST_IDLE || ps2_valid) ? '0 : tmo_reg + TMO_W'(1);

      if (make_fire) begin
        if (is_lshift)      shift_l_reg <= 1'b1;
        else if (is_rshift) shift_r_reg <= 1'b1;
        else if (is_lctrl)  ctrl_l_reg  <= 1'b1;
        else if (is_rctrl)  ctrl_r_reg  <= 1'b1;
        else if (is_caps) begin
          if (!caps_held_reg) caps_reg <= !caps_reg;
          caps_held_reg <= 1'b1;
        end else begin
          disp_code_reg  <= ps2_data;
          disp_ascii_reg <= ascii;
          disp_en_reg    <= 1'b1;
          held_reg       <= key;
        end
      end

      if (brk_fire) begin
        if (is_lshift)      shift_l_reg   <= 1'b0;
        else if (is_rshift) shift_r_reg   <= 1'b0;
        else if (is_lctrl)  ctrl_l_reg    <= 1'b0;
        else if (is_rctrl)  ctrl_r_reg    <= 1'b0;
        else if (is_caps)   caps_held_reg <= 1'b0;
        else begin
          key_cnt_reg <= key_cnt_reg + CNT_W'(1);
          if (key == held_reg) disp_en_reg <= 1'b0;
        end
      end

      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (drop)         ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= '{ext: ev_ext, ascii: ascii, code: ps2_data};
  end

  // Storage is not reset, so the head is masked until an entry exists.
  assign head       = mem[rd_ptr_reg[AW-1:0]];
  assign evt_valid  = (wr_ptr_reg != rd_ptr_reg);
  assign evt_code   = evt_valid ? head.code  : 8'h00;
  assign evt_ascii  = evt_valid ? head.ascii : 8'h00;
  assign evt_ext    = evt_valid & head.ext;
  assign disp_en    = disp_en_reg;
  assign disp_code  = disp_code_reg;
  assign disp_ascii = disp_ascii_reg;
  assign key_cnt    = key_cnt_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: two decoders (repeat suppression on/off) fed the same byte stream,
// checked against a flag-based reference model of the scancode rules.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [1:0] evt_valid, evt_ext, disp_en, shift_flag, ctrl_flag, caps_flag, ovf;
  logic [7:0] evt_code [2];
  logic [7:0] evt_ascii [2];
  logic [7:0] disp_code [2];
  logic [7:0] disp_ascii [2];
  logic [7:0] key_cnt [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ps2_key_decoder #(
      .FIFO_DEPTH(DEPTH), .CNT_W(8), .TIMEOUT_CYC(TMO), .SUPPRESS_RPT(gi == 0)
    ) dut (
      .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
      .evt_ready(evt_ready), .ovf_clr(ovf_clr),
      .evt_valid(evt_valid[gi]), .evt_code(evt_code[gi]), .evt_ascii(evt_ascii[gi]),
      .evt_ext(evt_ext[gi]), .disp_en(disp_en[gi]), .disp_code(disp_code[gi]),
      .disp_ascii(disp_ascii[gi]), .shift_flag(shift_flag[gi]), .ctrl_flag(ctrl_flag[gi]),
      .caps_flag(caps_flag[gi]), .key_cnt(key_cnt[gi]), .ovf(ovf[gi])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dcodes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] mods [4]    = '{8'h12, 8'h59, 8'h14, 8'h58};
  logic [7:0] specs [5]   = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  string digs = "1234567890";
  string syms = "!@#$%^&*()";
  bit    sup [2] = '{1'b1, 1'b0};

  bit         shl [2], shr [2], ctl [2], ctr [2], caps [2], caps_held [2];
  bit         pend_e0 [2], pend_f0 [2], den [2], m_ovf [2];
  int         pause_left [2], idle_cyc [2], occ [2];
  logic [8:0] held [2];
  logic [7:0] dcode [2], dascii [2], kcnt [2];
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit e,
                                             input bit sh, input bit ct, input bit cp);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (lcodes[i] == c) return ct ? 8'(i + 1) : ((sh ^ cp) ? 8'(65 + i) : 8'(97 + i));
    for (int i = 0; i < 10; i++)
      if (dcodes[i] == c) return sh ? syms[i] : digs[i];
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      shl[m] = 0; shr[m] = 0; ctl[m] = 0; ctr[m] = 0; caps[m] = 0; caps_held[m] = 0;
      pend_e0[m] = 0; pend_f0[m] = 0; den[m] = 0; m_ovf[m] = 0;
      pause_left[m] = 0; idle_cyc[m] = 0; occ[m] = 0;
      held[m] = '0; dcode[m] = '0; dascii[m] = '0; kcnt[m] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int m);
    bit mk, bk, e, pop, push, rep;
    logic [7:0] b, a;
    logic [8:0] k;
    mk = 0; bk = 0; e = 0; push = 0; b = ps2_data; a = 8'h00;
    pop = evt_ready && (occ[m] > 0);
    if (ps2_valid) begin
      idle_cyc[m] = 0;
      if (pause_left[m] > 0) pause_left[m]--;
      else if (pend_f0[m]) begin
        if (!(b == 8'hF0 && !pend_e0[m])) begin
          bk = 1; e = pend_e0[m]; pend_e0[m] = 0; pend_f0[m] = 0;
        end
      end
      else if (b == 8'hF0) pend_f0[m] = 1;
      else if (b == 8'hE0) pend_e0[m] = 1;
      else if (b == 8'hE1 && !pend_e0[m]) pause_left[m] = 7;
      else begin mk = 1; e = pend_e0[m]; pend_e0[m] = 0; end
    end else if (pend_e0[m] || pend_f0[m] || pause_left[m] > 0) begin
      idle_cyc[m]++;
      if (idle_cyc[m] == TMO) begin
        pend_e0[m] = 0; pend_f0[m] = 0; pause_left[m] = 0; idle_cyc[m] = 0;
      end
    end else idle_cyc[m] = 0;

    if (mk || bk) begin
      k = {e, b};
      if (k == 9'h012)      shl[m] = mk;
      else if (k == 9'h059) shr[m] = mk;
      else if (k == 9'h014) ctl[m] = mk;
      else if (k == 9'h114) ctr[m] = mk;
      else if (k == 9'h058) begin
        if (mk && !caps_held[m]) caps[m] = !caps[m];
        caps_held[m] = mk;
      end else if (mk) begin
        a = model_ascii(b, e, shl[m] | shr[m], ctl[m] | ctr[m], caps[m]);
        rep = den[m] && (held[m] == k);
        dcode[m] = b; dascii[m] = a; den[m] = 1; held[m] = k;
        push = !(sup[m] && rep);
      end else begin
        kcnt[m] = kcnt[m] + 8'd1;
        if (held[m] == k) den[m] = 0;
      end
    end

    if (push && (occ[m] < DEPTH || pop)) begin
      if (m == 0) q0.push_back({e, a, b});
      else        q1.push_back({e, a, b});
      occ[m]++;
    end
    if (pop) occ[m]--;
    if (push && occ[m] >= DEPTH && !pop && !(occ[m] == DEPTH && q_just_pushed(m, push, pop))) ;
    if (push && !pop && occ_full_before(m)) m_ovf[m] = 1;
    else if (ovf_clr) m_ovf[m] = 0;
  endtask

  // occ_full_before/q_just_pushed keep the drop decision readable: a push is dropped
  // only when the model FIFO was already full and nothing left it on the same edge.
  bit full_at_edge [2];
  function automatic bit occ_full_before(input int m);
    return full_at_edge[m];
  endfunction
  function automatic bit q_just_pushed(input int m, input bit push, input bit pop);
    return push && !pop && (m >= 0);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) model_reset();
      else begin
        for (int m = 0; m < 2; m++) begin
          full_at_edge[m] = (occ[m] >= DEPTH);
          model_step(m);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [16:0] ent;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int m = 0; m < 2; m++) begin
          check($sformatf("evt_valid[%0d]", m), 32'(evt_valid[m]), 32'(occ[m] > 0));
          if (evt_valid[m] && evt_ready) begin
            if ((m == 0 ? q0.size() : q1.size()) == 0)
              check($sformatf("evt_extra[%0d]", m), 32'(evt_valid[m]), 32'd0);
            else begin
              ent = (m == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("evt_code[%0d]", m),  32'(evt_code[m]),  32'(ent[7:0]));
              check($sformatf("evt_ascii[%0d]", m), 32'(evt_ascii[m]), 32'(ent[15:8]));
              check($sformatf("evt_ext[%0d]", m),   32'(evt_ext[m]),   32'(ent[16]));
            end
          end
          check($sformatf("key_cnt[%0d]", m),    32'(key_cnt[m]),    32'(kcnt[m]));
          check($sformatf("disp_en[%0d]", m),    32'(disp_en[m]),    32'(den[m]));
          check($sformatf("disp_code[%0d]", m),  32'(disp_code[m]),  32'(dcode[m]));
          check($sformatf("disp_ascii[%0d]", m), 32'(disp_ascii[m]), 32'(dascii[m]));
          check($sformatf("shift_flag[%0d]", m), 32'(shift_flag[m]), 32'(shl[m] | shr[m]));
          check($sformatf("ctrl_flag[%0d]", m),  32'(ctrl_flag[m]),  32'(ctl[m] | ctr[m]));
          check($sformatf("caps_flag[%0d]", m),  32'(caps_flag[m]),  32'(caps[m]));
          check($sformatf("ovf[%0d]", m),        32'(ovf[m]),        32'(m_ovf[m]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit         rand_ready = 0;
  logic [7:0] last_key = 8'h1C;

  task automatic tick();
    @(posedge clk);
    #1;
    ps2_valid = 1'b0;
    if (rand_ready) begin
      evt_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 19) == 0);
    end else ovf_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap = 1);
    ps2_data  = b;
    ps2_valid = 1'b1;
    tick();
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_evt_valid[%0d]", m), 32'(evt_valid[m]), 32'd0);
      check($sformatf("rst_disp_en[%0d]", m),   32'(disp_en[m]),   32'd0);
      check($sformatf("rst_key_cnt[%0d]", m),   32'(key_cnt[m]),   32'd0);
      check($sformatf("rst_shift[%0d]", m),     32'(shift_flag[m]), 32'd0);
      check($sformatf("rst_ctrl[%0d]", m),      32'(ctrl_flag[m]), 32'd0);
      check($sformatf("rst_caps[%0d]", m),      32'(caps_flag[m]), 32'd0);
      check($sformatf("rst_ovf[%0d]", m),       32'(ovf[m]),       32'd0);
      check($sformatf("rst_disp_code[%0d]", m), 32'(disp_code[m]), 32'd0);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30)      return lcodes[$urandom_range(0, 25)];
    else if (r < 40) return dcodes[$urandom_range(0, 9)];
    else if (r < 48) return mods[$urandom_range(0, 3)];
    else if (r < 58) return last_key;
    else if (r < 73) return 8'hF0;
    else if (r < 83) return 8'hE0;
    else if (r < 85) return 8'hE1;
    else if (r < 92) return specs[$urandom_range(0, 4)];
    else             return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] b;
    int g;
    do_reset();
    evt_ready = 1'b1;

    // plain make/break, shift, caps, shift under caps
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    // extended key, ctrl+letter, right ctrl
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h14); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h14); send(8'h1A); send(8'hF0); send(8'h1A); send(8'hE0); send(8'hF0); send(8'h14);
    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    // overflow with stalled consumer, then drop and clear on the same edge
    evt_ready = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    ovf_clr = 1'b1; send(8'h2B, 0);
    ovf_clr = 1'b1; tick();
    evt_ready = 1'b1;
    repeat (8) tick();
    send(8'hF0); send(8'h2B);
    // pause sequence swallows its 7 bytes
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14);
    send(8'hF0); send(8'h77); send(8'h1C); send(8'hF0); send(8'h1C);
    // timeout boundary: one cycle short keeps E0, full timeout drops it
    send(8'hE0, 0); repeat (TMO - 1) tick(); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0, 0); repeat (TMO) tick(); send(8'h1C); send(8'hF0); send(8'h1C);
    // reset in the middle of a break sequence
    send(8'h12); send(8'h1C); send(8'hF0);
    do_reset();
    evt_ready = 1'b1;

    // randomized byte stream
    rand_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      b = pick();
      if (b != 8'hF0 && b != 8'hE0 && b != 8'hE1) last_key = b;
      r_gap: begin
        g = $urandom_range(0, 99);
        if (g < 3) g = TMO - 1 + $urandom_range(0, 2);
        else       g = g % 3;
      end
      send(b, g);
    end

    rand_ready = 0;
    evt_ready = 1'b1;
    repeat (20) tick();
    check("q0_left", 32'(q0.size()), 32'd0);
    check("q1_left", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
